// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- MBIST sequencer and its compare pipeline.
package mbist_pkg;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} mbist_state_e;

  localparam int FAIL_CNT_W = 16;

  // Bit e set: element e issues two ops per address / walks addresses downward.
  localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [5:0] ELEM_DOWN    = 6'b011000;

  // The first op of every element except M0 is a read; M0 is a single write.
  function automatic logic op_is_read(march_elem_e e, logic op);
    return (e != M0) && !op;
  endfunction

  // Background bit carried by an op: expected data for reads, write data for writes.
  function automatic logic op_data(march_elem_e e, logic op);
    case (e)
      M1, M3:  return op;
      M2, M4:  return !op;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-latency alignment pipeline, registered comparator and fail/diagnostic capture.
// MBIST_MARCH_DIAG_EN builds the first-fail address/element and saturating fail count.
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int WLENGTH = 4,
  parameter int AW      = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [WLENGTH-1:0]    in_exp,
  input  logic [AW-1:0]         in_addr,
  input  logic [2:0]            in_elem,
  input  logic [WLENGTH-1:0]    mem_dout,
  output logic                  fail,
  output logic [AW-1:0]         fail_addr,
  output logic [2:0]            fail_elem,
  output logic [FAIL_CNT_W-1:0] fail_count
);

`ifdef MBIST_MARCH_DIAG_EN
  localparam int SW = 1 + WLENGTH + AW + 3;
`else
  localparam int SW = 1 + WLENGTH;
`endif

  logic [SW-1:0]      stage_in;
  logic [SW-1:0]      pipe_reg [RD_LAT];
  logic               exit_valid;
  logic [WLENGTH-1:0] exit_exp;
  logic               mism;

`ifdef MBIST_MARCH_DIAG_EN
  assign stage_in = {in_valid, in_exp, in_addr, in_elem};
`else
  assign stage_in = {in_valid, in_exp};
  logic unused_diag;
  assign unused_diag = ^{in_addr, in_elem};
`endif

  assign exit_valid = pipe_reg[RD_LAT-1][SW-1];
  assign exit_exp   = pipe_reg[RD_LAT-1][SW-2 -: WLENGTH];
  assign mism       = exit_valid && (mem_dout != exit_exp);

  // Stage k holds the op presented k+1 cycles ago, so the last stage lines up with mem_dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= stage_in;
      for (int i = 1; i < RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

`ifdef MBIST_MARCH_DIAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (clr) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (mism) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr <= pipe_reg[RD_LAT-1][AW+2:3];
        fail_elem <= pipe_reg[RD_LAT-1][2:0];
      end
      if (fail_count != {FAIL_CNT_W{1'b1}}) fail_count <= fail_count + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      fail <= 1'b0;
    else if (clr)  fail <= 1'b0;
    else if (mism) fail <= 1'b1;
  end
  assign fail_addr  = '0;
  assign fail_elem  = '0;
  assign fail_count = '0;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: issues one SRAM op per cycle and reports pass/fail.
// MBIST_MARCH_DIAG_EN enables first-fail diagnostics in the compare pipeline.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int WCOUNT  = 256,
  parameter int WLENGTH = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WLENGTH-1:0]        mem_dout,
  output logic                      test_mode,
  output logic [$clog2(WCOUNT)-1:0] mem_addr,
  output logic [WLENGTH-1:0]        mem_din,
  output logic                      mem_rwbar,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [$clog2(WCOUNT)-1:0] fail_addr,
  output logic [2:0]                fail_elem,
  output logic [FAIL_CNT_W-1:0]     fail_count
);

  localparam int            AW        = $clog2(WCOUNT);
  localparam logic [AW-1:0] ADDR_LAST = AW'(WCOUNT - 1);

  mbist_state_e  st_reg;
  march_elem_e   elem_reg, elem_next;
  logic          op_reg, op_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [2:0]    drain_cnt_reg;
  logic          last_op, at_end, run_last, accept;

  assign accept = start && (st_reg == S_IDLE || st_reg == S_DONE);

  // Successor of the op currently on the bus; explicit end compares keep odd WCOUNT in range.
  always_comb begin
    last_op   = !ELEM_TWO_OPS[elem_reg] || op_reg;
    at_end    = ELEM_DOWN[elem_reg] ? (addr_reg == '0) : (addr_reg == ADDR_LAST);
    run_last  = (elem_reg == M5) && last_op && at_end;
    elem_next = elem_reg;
    op_next   = op_reg;
    addr_next = addr_reg;
    if (!last_op) begin
      op_next = 1'b1;
    end else if (!at_end) begin
      op_next   = 1'b0;
      addr_next = ELEM_DOWN[elem_reg] ? addr_reg - 1'b1 : addr_reg + 1'b1;
    end else begin
      op_next   = 1'b0;
      elem_next = march_elem_e'(elem_reg + 3'd1);
      addr_next = ELEM_DOWN[elem_next] ? ADDR_LAST : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg        <= S_IDLE;
      elem_reg      <= M0;
      op_reg        <= 1'b0;
      addr_reg      <= '0;
      drain_cnt_reg <= '0;
      test_mode     <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_rwbar     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (st_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            st_reg    <= S_RUN;
            elem_reg  <= M0;
            op_reg    <= 1'b0;
            addr_reg  <= '0;
            test_mode <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_rwbar <= 1'b0;
          end
        end
        S_RUN: begin
          if (run_last) begin
            // Park on harmless reads while the last read data drains through the compare.
            st_reg        <= S_DRAIN;
            drain_cnt_reg <= '0;
            mem_addr      <= '0;
            mem_din       <= '0;
            mem_rwbar     <= 1'b1;
          end else begin
            elem_reg  <= elem_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            mem_addr  <= addr_next;
            mem_din   <= {WLENGTH{op_data(elem_next, op_next)}};
            mem_rwbar <= op_is_read(elem_next, op_next);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_reg == 3'(RD_LAT)) begin
            st_reg    <= S_DONE;
            test_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            mem_rwbar <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        default: st_reg <= S_IDLE;
      endcase
    end
  end

  mbist_cmp_pipe #(
    .WLENGTH (WLENGTH),
    .AW      (AW),
    .RD_LAT  (RD_LAT)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .in_valid   ((st_reg == S_RUN) && mem_rwbar),
    .in_exp     (mem_din),
    .in_addr    (mem_addr),
    .in_elem    (elem_reg),
    .mem_dout   (mem_dout),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_count (fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (RD_LAT 1 and 3) against SRAM models with injected stuck-at faults.
module tb_mbist_march_ctrl;

  localparam int W    = 16;
  localparam int WL   = 4;
  localparam int AW   = 4;
  localparam int NOPS = 10 * W;
`ifdef MBIST_MARCH_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [WL-1:0] dout_1, din_1, dout_3, din_3;
  logic [AW-1:0] addr_1, faddr_1, addr_3, faddr_3;
  logic          tm_1, rw_1, busy_1, done_1, fail_1;
  logic          tm_3, rw_3, busy_3, done_3, fail_3;
  logic [2:0]    felem_1, felem_3;
  logic [15:0]   fcnt_1, fcnt_3;
  logic [35:0]   out_all_1, out_all_3;

  mbist_march_ctrl #(.WCOUNT(W), .WLENGTH(WL), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mem_dout(dout_1), .test_mode(tm_1),
    .mem_addr(addr_1), .mem_din(din_1), .mem_rwbar(rw_1), .busy(busy_1), .done(done_1),
    .fail(fail_1), .fail_addr(faddr_1), .fail_elem(felem_1), .fail_count(fcnt_1));

  mbist_march_ctrl #(.WCOUNT(W), .WLENGTH(WL), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mem_dout(dout_3), .test_mode(tm_3),
    .mem_addr(addr_3), .mem_din(din_3), .mem_rwbar(rw_3), .busy(busy_3), .done(done_3),
    .fail(fail_3), .fail_addr(faddr_3), .fail_elem(felem_3), .fail_count(fcnt_3));

  assign out_all_1 = {tm_1, addr_1, din_1, rw_1, busy_1, done_1, fail_1, faddr_1, felem_1, fcnt_1};
  assign out_all_3 = {tm_3, addr_3, din_3, rw_3, busy_3, done_3, fail_3, faddr_3, felem_3, fcnt_3};

  // Fault: one bit of one word reads back stuck at fault_val.
  logic fault_en = 1'b0;
  int   fault_addr = 0;
  int   fault_bit = 0;
  logic fault_val = 1'b0;

  function automatic logic [WL-1:0] faulty(int a, logic [WL-1:0] d);
    logic [WL-1:0] r;
    r = d;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // SRAM models: read data valid RD_LAT cycles after the op is presented.
  logic [WL-1:0] ram_1 [W];
  logic [WL-1:0] ram_3 [W];
  logic [WL-1:0] rq_1;
  logic [WL-1:0] rq_3 [3];

  always @(posedge clk) begin
    if (tm_1) begin
      if (!rw_1) ram_1[addr_1] <= din_1;
      rq_1 <= faulty(int'(addr_1), ram_1[addr_1]);
    end
  end

  always @(posedge clk) begin
    if (tm_3) begin
      if (!rw_3) ram_3[addr_3] <= din_3;
      rq_3[0] <= faulty(int'(addr_3), ram_3[addr_3]);
    end
    rq_3[1] <= rq_3[0];
    rq_3[2] <= rq_3[1];
  end

  assign dout_1 = rq_1;
  assign dout_3 = rq_3[2];

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [WL-1:0] data;
  } op_t;

  op_t exp_q[$];
  op_t act_q[$];
  int  m_cnt, m_addr, m_elem;
  int  vectors = 0;
  int  miscompares = 0;
  int  dur_1, dur_3, drain_bad;
  logic [3:0] snap0_1, snap0_3;

  // Reference: walk the March C- elements over an array memory, recording ops and failing reads.
  task automatic build_model();
    logic [WL-1:0] m [W];
    logic [5:0] rd_bg = 6'b010100;
    logic [5:0] wr_bg = 6'b001010;
    exp_q.delete();
    m_cnt = 0; m_addr = 0; m_elem = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < W; k++) begin
        int a;
        a = (e == 3 || e == 4) ? W - 1 - k : k;
        if (e != 0) begin
          exp_q.push_back('{1'b1, AW'(a), {WL{rd_bg[e]}}});
          if (faulty(a, m[a]) != {WL{rd_bg[e]}}) begin
            if (m_cnt == 0) begin m_addr = a; m_elem = e; end
            m_cnt++;
          end
        end
        if (e != 5) begin
          m[a] = {WL{wr_bg[e]}};
          exp_q.push_back('{1'b0, AW'(a), {WL{wr_bg[e]}}});
        end
      end
    end
  endtask

  // Pulses start, then records ops, drain behaviour and done time (n = cycles after t+1).
  task automatic run_test(input int restart_at);
    act_q.delete();
    dur_1 = -1; dur_3 = -1; drain_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 400 && (dur_1 < 0 || dur_3 < 0); n++) begin
      if (n == 0) begin
        snap0_1 = {busy_1, tm_1, done_1, fail_1};
        snap0_3 = {busy_3, tm_3, done_3, fail_3};
      end
      if (n < NOPS && tm_1) act_q.push_back('{rw_1, addr_1, din_1});
      if (done_1 && dur_1 < 0) dur_1 = n;
      else if (n >= NOPS && dur_1 < 0 && !(tm_1 && rw_1)) drain_bad++;
      if (done_3 && dur_3 < 0) dur_3 = n;
      else if (n >= NOPS && dur_3 < 0 && !(tm_3 && rw_3)) drain_bad++;
      start = (n == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_all_1 !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_rl1 got=%h want=0", out_all_1);
    end
    vectors++;
    if (out_all_3 !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_rl3 got=%h want=0", out_all_3);
    end
    $display("reset: outputs rl1=%h rl3=%h", out_all_1, out_all_3);
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fault_free();
    int bad;
    fault_en = 1'b0;
    build_model();
    run_test(-1);
    $display("fault_free: dur1=%0d dur3=%0d ops=%0d fail1=%0b fail3=%0b", dur_1, dur_3, act_q.size(), fail_1, fail_3);
    vectors++;
    if (dur_1 !== NOPS + 2 || dur_3 !== NOPS + 4) begin
      miscompares++;
      $display("FAIL ff_duration got=%0d/%0d want=%0d/%0d", dur_1, dur_3, NOPS + 2, NOPS + 4);
    end
    vectors++;
    if (snap0_1 !== 4'b1100 || snap0_3 !== 4'b1100) begin
      miscompares++;
      $display("FAIL ff_start_latency got=%b/%b want=1100", snap0_1, snap0_3);
    end
    vectors++;
    if ({fail_1, fcnt_1, fail_3, fcnt_3} !== '0) begin
      miscompares++;
      $display("FAIL ff_result got fail=%0b/%0b cnt=%0d/%0d want 0", fail_1, fail_3, fcnt_1, fcnt_3);
    end
    vectors++;
    if (act_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL ff_op_count got=%0d want=%0d", act_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i].rw !== exp_q[i].rw || act_q[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rw && act_q[i].data !== exp_q[i].data)) begin
        miscompares++;
        if (bad < 8) $display("FAIL ff_op[%0d] got rw=%0b a=%0d d=%h want rw=%0b a=%0d d=%h",
                              i, act_q[i].rw, act_q[i].addr, act_q[i].data,
                              exp_q[i].rw, exp_q[i].addr, exp_q[i].data);
        bad++;
      end
    end
    vectors++;
    if (drain_bad !== 0) begin
      miscompares++;
      $display("FAIL ff_drain got=%0d bad cycles want=0", drain_bad);
    end
    vectors++;
    if ({tm_1, addr_1, din_1, rw_1, busy_1, done_1} !== 15'b1) begin
      miscompares++;
      $display("FAIL ff_done_idle_bus got=%b want=%b", {tm_1, addr_1, din_1, rw_1, busy_1, done_1}, 15'b1);
    end
  endtask

  task automatic test_fault(input string name, input int fa, input int fb, input logic fv);
    logic [23:0] want;
    fault_en = 1'b1; fault_addr = fa; fault_bit = fb; fault_val = fv;
    build_model();
    run_test(-1);
    want = DIAG ? {m_cnt != 0, AW'(m_addr), 3'(m_elem), 16'(m_cnt)} : {m_cnt != 0, 23'd0};
    $display("%s: addr=%0d bit=%0d sa%0b model cnt=%0d elem=%0d | rl1 fail=%0b a=%0d e=%0d c=%0d dur=%0d/%0d",
             name, fa, fb, fv, m_cnt, m_elem, fail_1, faddr_1, felem_1, fcnt_1, dur_1, dur_3);
    vectors++;
    if ({fail_1, faddr_1, felem_1, fcnt_1} !== want) begin
      miscompares++;
      $display("FAIL %s_rl1 got=%h want=%h", name, {fail_1, faddr_1, felem_1, fcnt_1}, want);
    end
    vectors++;
    if ({fail_3, faddr_3, felem_3, fcnt_3} !== want) begin
      miscompares++;
      $display("FAIL %s_rl3 got=%h want=%h", name, {fail_3, faddr_3, felem_3, fcnt_3}, want);
    end
    vectors++;
    if (dur_1 !== NOPS + 2 || dur_3 !== NOPS + 4) begin
      miscompares++;
      $display("FAIL %s_duration got=%0d/%0d want=%0d/%0d", name, dur_1, dur_3, NOPS + 2, NOPS + 4);
    end
  endtask

  task automatic test_stuck1();
    test_fault("stuck1_a5", 5, 0, 1'b1);
    vectors++;
    if (m_cnt !== 3 || m_elem !== 1 || m_addr !== 5) begin
      miscompares++;
      $display("FAIL stuck1_model got cnt=%0d elem=%0d addr=%0d want 3/1/5", m_cnt, m_elem, m_addr);
    end
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 4; i++)
      test_fault("rand_fault", int'($urandom_range(0, W - 1)), int'($urandom_range(0, WL - 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back();
    fault_en = 1'b1; fault_addr = 5; fault_bit = 0; fault_val = 1'b1;
    run_test(50);
    $display("start_while_busy: dur=%0d/%0d fail=%0b/%0b", dur_1, dur_3, fail_1, fail_3);
    vectors++;
    if (dur_1 !== NOPS + 2 || dur_3 !== NOPS + 4 || fail_1 !== 1'b1 || fail_3 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start got dur=%0d/%0d fail=%0b/%0b want %0d/%0d 1/1",
               dur_1, dur_3, fail_1, fail_3, NOPS + 2, NOPS + 4);
    end
    fault_en = 1'b0;
    build_model();
    run_test(-1);
    $display("restart_from_done: snap=%b/%b dur=%0d/%0d fail=%0b/%0b", snap0_1, snap0_3, dur_1, dur_3, fail_1, fail_3);
    vectors++;
    if (snap0_1 !== 4'b1100 || snap0_3 !== 4'b1100) begin
      miscompares++;
      $display("FAIL restart_clear got=%b/%b want=1100", snap0_1, snap0_3);
    end
    vectors++;
    if ({fail_1, fcnt_1, fail_3, fcnt_3} !== '0 || dur_1 !== NOPS + 2 || dur_3 !== NOPS + 4) begin
      miscompares++;
      $display("FAIL restart_result got fail=%0b/%0b dur=%0d/%0d want 0/0 %0d/%0d",
               fail_1, fail_3, dur_1, dur_3, NOPS + 2, NOPS + 4);
    end
  endtask

  task automatic test_reset_mid();
    logic was_busy;
    fault_en = 1'b1; fault_addr = 9; fault_bit = 2; fault_val = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (80) @(negedge clk);
    was_busy = busy_1 && busy_3 && tm_1 && tm_3;
    rst = 1'b0;
    #1;
    $display("reset_mid: busy_before=%0b outputs rl1=%h rl3=%h", was_busy, out_all_1, out_all_3);
    vectors++;
    if (!was_busy || out_all_1 !== '0 || out_all_3 !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got busy_before=%0b out=%h/%h want 1 0/0", was_busy, out_all_1, out_all_3);
    end
    @(negedge clk); rst = 1'b1;
    test_fault("after_reset", 9, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck1();
    test_random_faults();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
